// File: rtl/sd_rr_sched.sv
// Round-robin arbiter sharing one srdy/drdy consumer among several producers,
// with an optional burst lock and a registered, source-tagged output stage.
//
// state  | meaning
// IDLE   | no lock held; next transfer arbitrates round-robin from last+1
// LOCKED | grant held on port `last` until burst beats or it drops c_srdy
module sd_rr_sched #(
  parameter int inputs = 4,
  parameter int width  = 8,
  parameter int burst  = 4,
  parameter int sel_w  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic [sel_w-1:0]        p_src
);

  localparam int cnt_w = $clog2(burst + 1);
  localparam logic [cnt_w-1:0] burst_c = cnt_w'(burst);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q, state_d;
  logic [sel_w-1:0]   last_q, last_d;
  logic [cnt_w-1:0]   beat_cnt_q, beat_cnt_d;
  logic               p_srdy_q, p_srdy_d;
  logic [width-1:0]   p_data_q, p_data_d;
  logic [sel_w-1:0]   p_src_q, p_src_d;

  logic               ld;
  logic               valid_sel;
  logic               cont;
  logic [sel_w-1:0]   sel;
  logic [sel_w-1:0]   cand;

  always_comb begin
    ld        = !p_srdy_q | p_drdy;
    sel       = '0;
    cand      = '0;
    valid_sel = 1'b0;
    cont      = 1'b0;
    if (state_q == LOCKED && c_srdy[last_q]) begin
      sel       = last_q;
      valid_sel = 1'b1;
      cont      = 1'b1;
    end else begin
      // first requester strictly after the last grant, wrapping
      for (int k = 1; k <= inputs; k++) begin
        cand = sel_w'((int'(last_q) + k) % inputs);
        if (!valid_sel && c_srdy[cand]) begin
          sel       = cand;
          valid_sel = 1'b1;
        end
      end
    end

    c_drdy = '0;
    if (ld && valid_sel) c_drdy[sel] = 1'b1;

    state_d    = state_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    p_srdy_d   = p_srdy_q;
    p_data_d   = p_data_q;
    p_src_d    = p_src_q;

    if (ld) begin
      if (valid_sel) begin
        p_data_d   = c_data[int'(sel)*width +: width];
        p_src_d    = sel;
        p_srdy_d   = 1'b1;
        last_d     = sel;
        beat_cnt_d = cont ? beat_cnt_q + cnt_w'(1) : cnt_w'(1);
        state_d    = (beat_cnt_d < burst_c) ? LOCKED : IDLE;
      end else begin
        p_srdy_d = 1'b0;
        state_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      last_q     <= sel_w'(inputs - 1);
      beat_cnt_q <= '0;
      p_srdy_q   <= 1'b0;
      p_data_q   <= '0;
      p_src_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      beat_cnt_q <= beat_cnt_d;
      p_srdy_q   <= p_srdy_d;
      p_data_q   <= p_data_d;
      p_src_q    <= p_src_d;
    end
  end

  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;
  assign p_src  = p_src_q;

endmodule

// File: tb/tb_sd_rr_sched.sv
// Directed bench for sd_rr_sched: one instance with burst=1, one with burst=4.
// Producers send port*0x40 + per-port beat count, advancing on each handshake.
module tb_sd_rr_sched;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  s1, cd1, s4, cd4;
  logic [31:0] d1, d4;
  logic        pr1, pr4, ps1, ps4;
  logic [7:0]  pd1, pd4;
  logic [1:0]  pc1, pc4;
  logic [7:0]  cnt1 [4];
  logic [7:0]  cnt4 [4];

  int n_pass = 0;
  int n_chk  = 0;

  sd_rr_sched #(.inputs(4), .width(8), .burst(1), .sel_w(2)) u_b1 (
    .clk(clk), .reset_n(reset_n), .c_srdy(s1), .c_drdy(cd1), .c_data(d1),
    .p_srdy(ps1), .p_drdy(pr1), .p_data(pd1), .p_src(pc1));

  sd_rr_sched #(.inputs(4), .width(8), .burst(4), .sel_w(2)) u_b4 (
    .clk(clk), .reset_n(reset_n), .c_srdy(s4), .c_drdy(cd4), .c_data(d4),
    .p_srdy(ps4), .p_drdy(pr4), .p_data(pd4), .p_src(pc4));

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt1[i] <= 8'd0;
        cnt4[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s1[i] && cd1[i]) cnt1[i] <= cnt1[i] + 8'd1;
        if (s4[i] && cd4[i]) cnt4[i] <= cnt4[i] + 8'd1;
      end
    end
  end

  always_comb begin
    d1 = '0;
    d4 = '0;
    for (int i = 0; i < 4; i++) begin
      d1[i*8 +: 8] = 8'(i * 64) + cnt1[i];
      d4[i*8 +: 8] = 8'(i * 64) + cnt4[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    s1 = '0; s4 = '0; pr1 = 1'b0; pr4 = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst b1 p_srdy", 32'(ps1), 0);
    chk("rst b1 p_src", 32'(pc1), 0);
    chk("rst b1 p_data", 32'(pd1), 0);
    chk("rst b1 c_drdy", 32'(cd1), 0);
    chk("rst b4 p_srdy", 32'(ps4), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // burst=1, all ports valid: 0,1,2,3,0,... with per-source incrementing data
    s1 = 4'hF; pr1 = 1'b1;
    #1 chk("b1 first c_drdy", 32'(cd1), 32'h1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("b1 rr p_srdy", 32'(ps1), 1);
      chk("b1 rr p_src", 32'(pc1), 32'(k % 4));
      chk("b1 rr p_data", 32'(pd1), 32'((k % 4) * 64 + k / 4));
      if (k == 7) s1 = 4'b0010;
      #1 chk("b1 rr c_drdy", 32'(cd1), (k < 7) ? 32'(1 << ((k + 1) % 4)) : 32'h2);
    end

    // only port 1 requesting: granted every cycle
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("b1 solo p_srdy", 32'(ps1), 1);
      chk("b1 solo p_src", 32'(pc1), 1);
      chk("b1 solo p_data", 32'(pd1), 32'(8'h42 + j));
      if (j == 3) begin
        pr1 = 1'b0;
        s1 = 4'hF;
      end
      #1 chk("b1 solo c_drdy", 32'(cd1), (j < 3) ? 32'h2 : 32'h0);
    end

    // output stalled for 5 cycles: everything held
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("b1 stall p_srdy", 32'(ps1), 1);
      chk("b1 stall p_src", 32'(pc1), 1);
      chk("b1 stall p_data", 32'(pd1), 32'h45);
      chk("b1 stall c_drdy", 32'(cd1), 0);
    end
    pr1 = 1'b1;
    #1 chk("b1 resume c_drdy", 32'(cd1), 32'h4);
    // resume from port 2; port 1 has already sent 6 beats, the others 2
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("b1 resume p_src", 32'(pc1), 32'((2 + j) % 4));
      chk("b1 resume p_data", 32'(pd1),
          32'(((2 + j) % 4) * 64 + ((((2 + j) % 4) == 1) ? 6 : 2)));
    end
    s1 = '0;

    // burst=4, all ports valid: four beats per grant
    s4 = 4'hF; pr4 = 1'b1;
    #1 chk("b4 first c_drdy", 32'(cd4), 32'h1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("b4 burst p_srdy", 32'(ps4), 1);
      chk("b4 burst p_src", 32'(pc4), 32'(k / 4));
      chk("b4 burst p_data", 32'(pd4), 32'((k / 4) * 64 + k % 4));
      if (k == 15) s4 = 4'b1100;
      #1 chk("b4 burst c_drdy", 32'(cd4), (k < 15) ? 32'(1 << (((k + 1) / 4) % 4)) : 32'h4);
    end

    // port 2 valid for two beats only: early release to port 3 without a bubble
    @(negedge clk);
    chk("b4 early p_src", 32'(pc4), 2);
    chk("b4 early p_data", 32'(pd4), 32'h84);
    #1 chk("b4 early c_drdy", 32'(cd4), 32'h4);
    @(negedge clk);
    chk("b4 early p_src", 32'(pc4), 2);
    chk("b4 early p_data", 32'(pd4), 32'h85);
    s4 = 4'b1000;
    #1 chk("b4 release c_drdy", 32'(cd4), 32'h8);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("b4 p3 p_srdy", 32'(ps4), 1);
      chk("b4 p3 p_src", 32'(pc4), 3);
      chk("b4 p3 p_data", 32'(pd4), 32'(8'hC4 + j));
      #1 chk("b4 p3 c_drdy", 32'(cd4), 32'h8);
    end
    @(negedge clk);
    chk("b4 regrant p_src", 32'(pc4), 3);
    chk("b4 regrant p_data", 32'(pd4), 32'hC8);

    // reset in the middle of a port 3 burst
    #2 reset_n = 1'b0;
    #1 chk("b4 async rst p_srdy", 32'(ps4), 0);
    chk("b4 async rst p_src", 32'(pc4), 0);
    s4 = 4'hF;
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("b4 post rst c_drdy", 32'(cd4), 32'h1);
    @(negedge clk);
    chk("b4 post rst p_srdy", 32'(ps4), 1);
    chk("b4 post rst p_src", 32'(pc4), 0);
    chk("b4 post rst p_data", 32'(pd4), 32'h00);
    @(negedge clk);
    chk("b4 post rst lock p_src", 32'(pc4), 0);
    chk("b4 post rst lock p_data", 32'(pd4), 32'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
